ex_stage_unit: RTL

EX_STAGE_UNIT -- requirements
Module: ex_stage_unit

---
 rtl/ex_pkg.sv | 19 +
 rtl/ex_fwd_alu.sv | 87 ++++++++
 rtl/ex_stage_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and types for the execute stage.
//   FWD_REG / FWD_EXMEM / FWD_MEMWB : 2-bit operand source selects
//   ALU_ADD / ALU_SUB               : 1-bit ALU operation encodings
//   ex_state_t                      : NORMAL / SQUASH control states
package ex_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic {
    NORMAL = 1'b0,
    SQUASH = 1'b1
  } ex_state_t;

endpackage

// File: rtl/ex_fwd_alu.sv
// ex_fwd_alu: combinational datapath of the execute stage.
//   Operand forwarding muxes, immediate select, add/sub ALU, operand
//   equality compare and branch target adder.
// Configuration macro: EX_FWD_EN. When defined, fwd_ctrl_a/b pick the
//   operand source; when undefined, operands are always rs_data/rt_data and
//   the forwarding inputs are accepted but ignored.
// Ports:
//   fwd_ctrl_a, fwd_ctrl_b  in  2   operand source selects
//   rs_data, rt_data        in  W   register-file operands
//   ex_mem_fwd_data         in  W   result forwarded from EX/MEM
//   mem_wb_fwd_data         in  W   result forwarded from MEM/WB
//   r_i_sel_ctrl            in  1   1 = immediate as second ALU input
//   alu_ctrl                in  1   ALU_ADD / ALU_SUB
//   sign_ext_in             in  16  immediate field
//   pc_4                    in  W   PC + 4 of the instruction
//   alu_out                 out W   ALU result
//   opnd_b                  out W   forwarded operand B (store data)
//   ops_equal               out 1   forwarded A == forwarded B
//   branch_target           out W   pc_4 + (sext(imm) << 2)
module ex_fwd_alu
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        fwd_ctrl_a,
  input  logic [1:0]        fwd_ctrl_b,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] ex_mem_fwd_data,
  input  logic [DATA_W-1:0] mem_wb_fwd_data,
  input  logic              r_i_sel_ctrl,
  input  logic              alu_ctrl,
  input  logic [15:0]       sign_ext_in,
  input  logic [DATA_W-1:0] pc_4,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] opnd_b,
  output logic              ops_equal,
  output logic [DATA_W-1:0] branch_target
);

  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] alu_in_b;
  logic [DATA_W-1:0] imm_ext;

`ifdef EX_FWD_EN
  always_comb begin
    case (fwd_ctrl_a)
      FWD_REG:   opnd_a = rs_data;
      FWD_EXMEM: opnd_a = ex_mem_fwd_data;
      FWD_MEMWB: opnd_a = mem_wb_fwd_data;
      default:   opnd_a = rs_data;
    endcase
  end

  always_comb begin
    case (fwd_ctrl_b)
      FWD_REG:   opnd_b = rt_data;
      FWD_EXMEM: opnd_b = ex_mem_fwd_data;
      FWD_MEMWB: opnd_b = mem_wb_fwd_data;
      default:   opnd_b = rt_data;
    endcase
  end
`else
  // Forwarding is compiled out; keep the ports so the pipeline wiring is
  // identical in both builds.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ctrl_a, fwd_ctrl_b, ex_mem_fwd_data, mem_wb_fwd_data};
  assign opnd_a     = rs_data;
  assign opnd_b     = rt_data;
`endif

  assign imm_ext  = {{(DATA_W-16){sign_ext_in[15]}}, sign_ext_in};
  assign alu_in_b = r_i_sel_ctrl ? imm_ext : opnd_b;

  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_out = opnd_a + alu_in_b;
      ALU_SUB: alu_out = opnd_a - alu_in_b;
      default: alu_out = opnd_a + alu_in_b;
    endcase
  end

  // Branch compare always uses register/forwarded operands, never the immediate.
  assign ops_equal     = (opnd_a == opnd_b);
  assign branch_target = pc_4 + {imm_ext[DATA_W-3:0], 2'b00};

endmodule

// File: rtl/ex_stage_unit.sv
// ex_stage_unit: execute pipeline stage with EX/MEM output register,
//   valid/ready handshake and taken-branch squash control.
// Configuration macro: EX_FWD_EN (operand forwarding, see ex_fwd_alu).
// Ports:
//   clk, rst                           clock, async active-high reset
//   id_ex_valid / id_ex_ready          upstream handshake
//   id_ex_* controls and data          decoded instruction contents
//   ex_mem_fwd_data, mem_wb_fwd_data   forwarded results
//   mem_ready                          downstream accepts EX/MEM
//   ex_mem_*                           registered EX/MEM contents
//   branch_taken, branch_target        one-cycle redirect pulse and PC
//
// state  | meaning
// NORMAL | instructions execute and load EX/MEM; beq may be taken
// SQUASH | next squash_cnt accepted instructions are wrong-path, dropped
module ex_stage_unit
  import ex_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SQUASH_N = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ex_valid,
  output logic              id_ex_ready,
  input  logic              id_ex_w_enable,
  input  logic              id_ex_alu_ctrl,
  input  logic              id_ex_r_i_sel_ctrl,
  input  logic              id_ex_wb_mux_ctrl,
  input  logic              id_ex_fwd_dm_ctrl,
  input  logic              beq_and_in,
  input  logic [1:0]        id_ex_fwd_ctrl_a,
  input  logic [1:0]        id_ex_fwd_ctrl_b,
  input  logic [4:0]        id_ex_rd_out_addr,
  input  logic [15:0]       id_ex_sign_ext_in,
  input  logic [DATA_W-1:0] id_ex_pc_4_out,
  input  logic [DATA_W-1:0] id_ex_rs_data,
  input  logic [DATA_W-1:0] id_ex_rt_data,
  input  logic [DATA_W-1:0] ex_mem_fwd_data,
  input  logic [DATA_W-1:0] mem_wb_fwd_data,
  input  logic              mem_ready,
  output logic              ex_mem_valid,
  output logic              ex_mem_w_enable,
  output logic              ex_mem_wb_mux_ctrl,
  output logic              ex_mem_fwd_dm_ctrl,
  output logic [4:0]        ex_mem_rd_out_addr,
  output logic [DATA_W-1:0] ex_mem_alu_out,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target
);

  localparam logic [1:0] SQUASH_LOAD = 2'(SQUASH_N);

  ex_state_t         state;
  logic [1:0]        squash_cnt;
  logic              handshake;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] opnd_b;
  logic              ops_equal;
  logic [DATA_W-1:0] tgt;

  assign id_ex_ready = !ex_mem_valid || mem_ready;
  assign handshake   = id_ex_valid && id_ex_ready;

  ex_fwd_alu #(.DATA_W(DATA_W)) u_fwd_alu (
    .fwd_ctrl_a      (id_ex_fwd_ctrl_a),
    .fwd_ctrl_b      (id_ex_fwd_ctrl_b),
    .rs_data         (id_ex_rs_data),
    .rt_data         (id_ex_rt_data),
    .ex_mem_fwd_data (ex_mem_fwd_data),
    .mem_wb_fwd_data (mem_wb_fwd_data),
    .r_i_sel_ctrl    (id_ex_r_i_sel_ctrl),
    .alu_ctrl        (id_ex_alu_ctrl),
    .sign_ext_in     (id_ex_sign_ext_in),
    .pc_4            (id_ex_pc_4_out),
    .alu_out         (alu_res),
    .opnd_b          (opnd_b),
    .ops_equal       (ops_equal),
    .branch_target   (tgt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= NORMAL;
      squash_cnt         <= 2'd0;
      ex_mem_valid       <= 1'b0;
      ex_mem_w_enable    <= 1'b0;
      ex_mem_wb_mux_ctrl <= 1'b0;
      ex_mem_fwd_dm_ctrl <= 1'b0;
      ex_mem_rd_out_addr <= 5'd0;
      ex_mem_alu_out     <= '0;
      ex_mem_store_data  <= '0;
      branch_taken       <= 1'b0;
      branch_target      <= '0;
    end else begin
      branch_taken <= 1'b0;
      if (handshake) begin
        case (state)
          NORMAL: begin
            ex_mem_valid       <= 1'b1;
            ex_mem_w_enable    <= id_ex_w_enable;
            ex_mem_wb_mux_ctrl <= id_ex_wb_mux_ctrl;
            ex_mem_fwd_dm_ctrl <= id_ex_fwd_dm_ctrl;
            ex_mem_rd_out_addr <= id_ex_rd_out_addr;
            ex_mem_alu_out     <= alu_res;
            ex_mem_store_data  <= opnd_b;
            if (beq_and_in && ops_equal) begin
              branch_taken  <= 1'b1;
              branch_target <= tgt;
              state         <= SQUASH;
              squash_cnt    <= SQUASH_LOAD;
            end
          end
          SQUASH: begin
            // Wrong-path instruction: consume it, leave EX/MEM data untouched.
            ex_mem_valid <= 1'b0;
            squash_cnt   <= squash_cnt - 2'd1;
            if (squash_cnt == 2'd1) state <= NORMAL;
          end
          default: state <= NORMAL;
        endcase
      end else if (id_ex_ready) begin
        ex_mem_valid <= 1'b0;
      end
    end
  end

endmodule
